sprite_pixel_pipe: RTL and testbench

//  Parametrised sprite pixel fetcher for the VGA display path. Maps the vgac scan position onto
//  one frame of a multi-frame sprite sheet held in a single synchronous ROM. Supports horizontal

---
 rtl/sprite_pixel_pipe_if.sv | 23 ++
 rtl/sprite_pixel_pipe.sv | 119 +++++++++++
 tb/tb_sprite_pixel_pipe.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pixel_pipe_if.sv
// rtl/sprite_pixel_pipe_if.sv - scan, sprite-sheet ROM and pixel-out bundle for sprite_pixel_pipe
interface sprite_pixel_pipe_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 16
);
    logic [9:0]         col;
    logic [8:0]         row;
    logic               frame_start;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [COLOR_W-1:0] color;
    logic               opaque;

    modport master (
        input  col, row, frame_start, rom_data,
        output rom_addr, color, opaque
    );

    modport slave (
        output col, row, frame_start, rom_data,
        input  rom_addr, color, opaque
    );
endinterface

// File: rtl/sprite_pixel_pipe.sv
// rtl/sprite_pixel_pipe.sv - sprite-sheet pixel fetcher with mirroring and frame-latched animation
module sprite_pixel_pipe #(
    parameter int                 SPR_W       = 34,
    parameter int                 SPR_H       = 36,
    parameter int                 NFRAMES     = 16,
    parameter int                 FRAME_BITS  = 4,
    parameter int                 ADDR_W      = 15,
    parameter int                 COLOR_W     = 16,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 16'hffff,
    parameter int                 ANIM_DIV    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sprite_pixel_pipe_if.master   bus,
    input  logic [9:0]            posx,
    input  logic [8:0]            posy,
    input  logic [FRAME_BITS-1:0] frame_req,
    input  logic [FRAME_BITS-1:0] anim_last,
    input  logic                  anim_en,
    input  logic                  mirror
);
    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [ADDR_W-1:0]     FRAME_SZ  = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0]     SPR_W_A   = ADDR_W'(SPR_W);
    localparam logic [FRAME_BITS-1:0] LAST_FRM  = FRAME_BITS'(NFRAMES - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(ANIM_DIV - 1);

    logic [FRAME_BITS-1:0] active_frame, base_q;
    logic                  mirror_q;
    logic [CNT_W-1:0]      anim_cnt;
    logic                  hit1, hit2;

    logic [FRAME_BITS-1:0] fr_s, al_s;
    logic [FRAME_BITS-1:0] nxt_frame, nxt_base;
    logic [CNT_W-1:0]      nxt_cnt;

    // Out-of-range frame indices fall back to frame 0.
    always_comb begin
        fr_s = (32'(frame_req) < NFRAMES) ? frame_req : '0;
        al_s = (32'(anim_last) < NFRAMES) ? anim_last : '0;
    end

    always_comb begin
        nxt_frame = active_frame;
        nxt_base  = base_q;
        nxt_cnt   = anim_cnt;
        if (!anim_en || (fr_s != base_q)) begin
            nxt_frame = fr_s;
            nxt_base  = fr_s;
            nxt_cnt   = '0;
        end else if (anim_cnt == CNT_LAST) begin
            nxt_cnt = '0;
            if ((active_frame == al_s) || (active_frame == LAST_FRM))
                nxt_frame = fr_s;
            else
                nxt_frame = active_frame + 1'b1;
        end else begin
            nxt_cnt = anim_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_frame <= '0;
            base_q       <= '0;
            mirror_q     <= 1'b0;
            anim_cnt     <= '0;
        end else if (bus.frame_start) begin
            active_frame <= nxt_frame;
            base_q       <= nxt_base;
            mirror_q     <= mirror;
            anim_cnt     <= nxt_cnt;
        end
    end

    // Pixels issued on the frame_start cycle already see the new frame state.
    logic [FRAME_BITS-1:0] eff_frame;
    logic                  eff_mirror;
    always_comb begin
        eff_frame  = bus.frame_start ? nxt_frame : active_frame;
        eff_mirror = bus.frame_start ? mirror    : mirror_q;
    end

    // Extended-width bounds so a sprite at the right/bottom edge clips instead of wrapping.
    logic [10:0]       x_end;
    logic [9:0]        y_end;
    logic              hit;
    logic [9:0]        lx_raw, lx;
    logic [8:0]        ly;
    logic [ADDR_W-1:0] addr_c;

    always_comb begin
        x_end  = {1'b0, posx} + 11'(SPR_W);
        y_end  = {1'b0, posy} + 10'(SPR_H);
        hit    = (bus.col >= posx) && ({1'b0, bus.col} < x_end) &&
                 (bus.row >= posy) && ({1'b0, bus.row} < y_end);
        lx_raw = bus.col - posx;
        lx     = eff_mirror ? (10'(SPR_W - 1) - lx_raw) : lx_raw;
        ly     = bus.row - posy;
        addr_c = ADDR_W'(eff_frame) * FRAME_SZ + ADDR_W'(ly) * SPR_W_A + ADDR_W'(lx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rom_addr <= '0;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            bus.color    <= TRANSPARENT;
            bus.opaque   <= 1'b0;
        end else begin
            if (hit)
                bus.rom_addr <= addr_c;
            hit1       <= hit;
            hit2       <= hit1;
            bus.color  <= hit2 ? bus.rom_data : TRANSPARENT;
            bus.opaque <= hit2 && (bus.rom_data != TRANSPARENT);
        end
    end
endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// tb/tb_sprite_pixel_pipe.sv - directed and randomized bench for sprite_pixel_pipe
module tb_sprite_pixel_pipe;
    localparam int SPR_W      = 34;
    localparam int SPR_H      = 36;
    localparam int NFRAMES    = 16;
    localparam int FRAME_BITS = 4;
    localparam int ADDR_W     = 15;
    localparam int COLOR_W    = 16;
    localparam int ANIM_DIV   = 2;
    localparam logic [15:0] TRANSP = 16'hffff;
    localparam int FSZ = SPR_W * SPR_H;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_pixel_pipe_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

    logic [9:0]            posx;
    logic [8:0]            posy;
    logic [FRAME_BITS-1:0] frame_req, anim_last;
    logic                  anim_en, mirror;

    sprite_pixel_pipe #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NFRAMES(NFRAMES), .FRAME_BITS(FRAME_BITS),
        .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .TRANSPARENT(TRANSP), .ANIM_DIV(ANIM_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .posx(posx), .posy(posy), .frame_req(frame_req), .anim_last(anim_last),
        .anim_en(anim_en), .mirror(mirror)
    );

    logic [15:0] rom_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int n_checks = 0;
    int n_pass   = 0;
    int m_frame, m_base, m_cnt;
    bit m_mirror;
    logic [31:0] last_fs_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit m_hit(input int c, input int r);
        int px, py;
        px = int'(posx);
        py = int'(posy);
        return (c >= px) && (c < px + SPR_W) && (r >= py) && (r < py + SPR_H);
    endfunction

    function automatic int m_addr(input int c, input int r);
        int lx;
        lx = c - int'(posx);
        if (m_mirror) lx = SPR_W - 1 - lx;
        return m_frame * FSZ + (r - int'(posy)) * SPR_W + lx;
    endfunction

    task automatic model_reset();
        m_frame = 0; m_base = 0; m_cnt = 0; m_mirror = 0;
    endtask

    task automatic model_fs();
        int fr, al;
        fr = (int'(frame_req) < NFRAMES) ? int'(frame_req) : 0;
        al = (int'(anim_last) < NFRAMES) ? int'(anim_last) : 0;
        m_mirror = mirror;
        if (!anim_en || fr != m_base) begin
            m_frame = fr; m_base = fr; m_cnt = 0;
        end else if (m_cnt == ANIM_DIV - 1) begin
            m_cnt = 0;
            m_frame = (m_frame == al || m_frame == NFRAMES - 1) ? fr : m_frame + 1;
        end else begin
            m_cnt++;
        end
    endtask

    // Frame-start pulse coincident with the sprite's top-left pixel.
    task automatic pulse_fs(input string tag);
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.col = posx;
        bus.row = posy;
        model_fs();
        @(posedge clk);
        #1;
        last_fs_addr = 32'(bus.rom_addr);
        chk(tag, last_fs_addr, 32'(m_addr(int'(posx), int'(posy))));
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic scan(input string tag, input int c, input int r);
        logic [15:0] exp_c;
        bit h;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.col = 10'(c);
        bus.row = 9'(r);
        h = m_hit(c, r);
        @(posedge clk);
        #1;
        if (h) chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(m_addr(c, r)));
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_c = h ? rom_mem[m_addr(c, r)] : TRANSP;
        chk({tag, "_color"}, 32'(bus.color), 32'(exp_c));
        chk({tag, "_opaque"}, 32'(bus.opaque), 32'(h && exp_c != TRANSP));
    endtask

    initial begin
        int seq [8];
        int c, r;
        seq = '{4, 4, 5, 5, 6, 6, 4, 4};
        for (int i = 0; i < (1 << ADDR_W); i++)
            rom_mem[i] = ($urandom_range(0, 7) == 0) ? TRANSP : 16'($urandom_range(0, 16'hfffe));

        rst_n = 1'b1;
        bus.col = '0; bus.row = '0; bus.frame_start = 1'b0;
        posx = 10'd100; posy = 9'd50;
        frame_req = 4'd2; anim_last = '0; anim_en = 1'b0; mirror = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_color", 32'(bus.color), 32'(TRANSP));
        chk("rst_opaque", 32'(bus.opaque), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        pulse_fs("fs_frame2");
        chk("fs_frame2_const", last_fs_addr, 32'd2448);
        scan("origin", 100, 50);
        scan("right_edge_out", 134, 50);
        scan("left_edge_out", 99, 50);
        scan("right_edge_in", 133, 85);

        posx = 10'd1010;
        for (int i = 0; i < 6; i++) scan("no_wrap", i, 60);
        scan("clip_in", 1023, 60);
        posx = 10'd100;

        mirror = 1'b1; frame_req = 4'd0;
        pulse_fs("fs_mirror");
        chk("mirror_tl_const", last_fs_addr, 32'd33);
        scan("mirror_tl", 100, 50);
        scan("mirror_br", 133, 85);

        mirror = 1'b0; frame_req = 4'd2;
        pulse_fs("fs_back2");
        frame_req = 4'd5;
        mirror = 1'b1;
        scan("midframe_hold", 110, 60);
        pulse_fs("fs_frame5");
        mirror = 1'b0;
        pulse_fs("fs_frame5b");
        chk("frame5_const", last_fs_addr, 32'(5 * FSZ));

        anim_en = 1'b1; frame_req = 4'd4; anim_last = 4'd6;
        for (int i = 0; i < 8; i++) begin
            pulse_fs("anim_fs");
            chk("anim_seq", last_fs_addr, 32'(seq[i] * FSZ));
        end

        frame_req = 4'd14; anim_last = 4'd3;
        for (int i = 0; i < 6; i++) pulse_fs("anim_wrap");

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                posx = 10'($urandom_range(0, 1023));
                posy = 9'($urandom_range(0, 511));
                mirror = 1'($urandom_range(0, 1));
                anim_en = 1'($urandom_range(0, 1));
                frame_req = 4'($urandom_range(0, 15));
                anim_last = 4'($urandom_range(0, 15));
                pulse_fs("rnd_fs");
            end
            c = (int'(posx) + int'($urandom_range(0, 40)) - 3) & 1023;
            r = (int'(posy) + int'($urandom_range(0, 42)) - 3) & 511;
            scan("rnd", c, r);
        end

        posx = 10'd100; posy = 9'd50; anim_en = 1'b0; mirror = 1'b0; frame_req = 4'd3;
        rom_mem[3 * FSZ + 10 * SPR_W + 10] = 16'h1234;
        pulse_fs("fs_pre_rst");
        scan("pre_rst", 110, 60);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_color", 32'(bus.color), 32'(TRANSP));
        chk("midrst_opaque", 32'(bus.opaque), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_color", 32'(bus.color), 32'(rom_mem[m_addr(110, 60)]));
        chk("post_rst_opaque", 32'(bus.opaque), 32'(rom_mem[m_addr(110, 60)] != TRANSP));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
